// File: rtl/sha2_stream_core.sv
// Iterative SHA-256 / SHA-224 compression core: one round per cycle, chaining
// across blocks, valid/ready handshakes on the block input and digest output.
module sha2_stream_core #(
    parameter int DIGEST_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [511:0]           block_in,
    input  logic                   block_first,
    input  logic                   block_last,
    input  logic                   block_valid,
    output logic                   block_ready,
    output logic [DIGEST_BITS-1:0] digest,
    output logic                   digest_valid,
    input  logic                   digest_ready,
    output logic                   busy
);

    // Handshake rule: a transfer happens on a rising edge where valid and
    // ready are both high; the sender holds its payload until then.

    if (DIGEST_BITS != 256 && DIGEST_BITS != 224) begin : g_bad_digest_bits
        $error("sha2_stream_core: DIGEST_BITS must be 224 or 256");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ROUND  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [255:0] IV = (DIGEST_BITS == 224) ?
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4 :
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        k = 32'h0;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [31:0] h_q [8];
    logic [31:0] h_d [8];
    logic [31:0] wv_q [8];
    logic [31:0] wv_d [8];
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];

    logic [31:0] t1, t2, w_next;

    // w_q[0] is always W[t] for the current round; w_q[15] is the newest word.
    always_comb begin
        t1 = wv_q[7] + big_sigma1(wv_q[4]) + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
             + k_rom(cnt_q) + w_q[0];
        t2 = big_sigma0(wv_q[0]) + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
        w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        for (int i = 0; i < 8; i++) begin
            h_d[i]  = h_q[i];
            wv_d[i] = wv_q[i];
        end
        for (int i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (block_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[511-32*i -: 32];
                    end
                    // A first block restarts H from the IV so UPDATE adds onto the IV.
                    for (int i = 0; i < 8; i++) begin
                        wv_d[i] = block_first ? IV[255-32*i -: 32] : h_q[i];
                        if (block_first) begin
                            h_d[i] = IV[255-32*i -: 32];
                        end
                    end
                    last_d  = block_last;
                    cnt_d   = 6'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                wv_d[7] = wv_q[6];
                wv_d[6] = wv_q[5];
                wv_d[5] = wv_q[4];
                wv_d[4] = wv_q[3] + t1;
                wv_d[3] = wv_q[2];
                wv_d[2] = wv_q[1];
                wv_d[1] = wv_q[0];
                wv_d[0] = t1 + t2;
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i+1];
                end
                w_d[15] = w_next;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wv_q[i];
                end
                state_d = last_q ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            last_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV[255-32*i -: 32];
                wv_q[i] <= 32'h0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= h_d[i];
                wv_q[i] <= wv_d[i];
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign block_ready  = (state_q == S_IDLE);
    assign digest_valid = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);

    // SHA-224 keeps H0..H6; the digest reads zero outside DONE.
    always_comb begin
        digest = '0;
        if (state_q == S_DONE) begin
            for (int i = 0; i < DIGEST_BITS/32; i++) begin
                digest[DIGEST_BITS-1-32*i -: 32] = h_q[i];
            end
        end
    end

endmodule
